// File: rtl/rw_test_pkg.sv
// Shared definitions for the DRAM read/write test initiator and its responder:
// phase encoding (also decoded by the initiator's status logic) and the legal
// read-latency range.
package rw_test_pkg;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_WRITE = 2'd1,
    PH_READ  = 2'd2,
    PH_DONE  = 2'd3
  } phase_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  function automatic bit rd_lat_ok(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/rw_test_responder_if.sv
// Strobe/data bus between the read/write test initiator (master) and the
// memory-side responder (slave), plus the responder's status outputs.
interface rw_test_responder_if
  import rw_test_pkg::*;
#(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16
);
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              read;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  phase_e            phase;
  logic [ADDR_W-1:0] ptr;
  logic              proto_err;

  modport master (
    output write, writedata, read,
    input  readdata, readdatavalid, phase, ptr, proto_err
  );

  modport slave (
    input  write, writedata, read,
    output readdata, readdatavalid, phase, ptr, proto_err
  );
endinterface

// File: rtl/rw_resp_mem.sv
// Single-port synchronous RAM, 2^AW x DW, registered read. Write and read are
// never requested together by the responder, so one address port suffices.
module rw_resp_mem #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  // Storage write and registered read; rdata holds when no read is issued.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/rw_test_responder.sv
// Memory-side responder for the DRAM read/write test initiator. Keeps its own
// auto-incrementing pointer, stores writes in on-chip RAM and returns reads
// RD_LAT edges after the strobe.
// Optional: define RW_RESP_ERR_INJECT_EN to add iINJECT, which flips bit 0 of
// the data returned for a read accepted while it is high.
module rw_test_responder
  import rw_test_pkg::*;
#(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16,
  parameter int MEM_AW = 10,
  parameter int RD_LAT = 2
) (
  input logic iCLK,
  input logic iRST_n,
`ifdef RW_RESP_ERR_INJECT_EN
  input logic iINJECT,
`endif
  rw_test_responder_if.slave bus
);

  if (MEM_AW > ADDR_W || !rd_lat_ok(RD_LAT)) begin : g_bad_param
    $error("rw_test_responder: need MEM_AW <= ADDR_W and RD_LAT in 1..4");
  end

  localparam logic [ADDR_W-1:0] PTR_ONE = 1;

  phase_e            phase_q, phase_nxt;
  logic [ADDR_W-1:0] ptr_q, addr;
  logic              acc_wr, acc_rd, err_set, err_q;
  logic [DATA_W-1:0] ram_q, ram_x, ret_data, rdata_q;
  // vld_pipe[0] lines up with the RAM output register; vld_pipe[RD_LAT] is the
  // readdatavalid pulse.
  logic [RD_LAT:0]   vld_pipe;

  // Decode strobes against the current phase: which access is accepted, at
  // which address, and whether the strobe pattern is a protocol error.
  always_comb begin
    acc_wr    = 1'b0;
    acc_rd    = 1'b0;
    err_set   = 1'b0;
    addr      = ptr_q;
    phase_nxt = phase_q;
    if (bus.write && bus.read) begin
      err_set = 1'b1;
    end else if (bus.write) begin
      unique case (phase_q)
        PH_IDLE, PH_DONE: begin
          // Start of a pass: the first write always lands at address 0.
          acc_wr    = 1'b1;
          addr      = '0;
          phase_nxt = PH_WRITE;
        end
        PH_WRITE: acc_wr  = 1'b1;
        PH_READ:  err_set = 1'b1;
      endcase
    end else if (bus.read) begin
      unique case (phase_q)
        PH_IDLE, PH_WRITE: begin
          // Read-back always restarts from address 0 after the write sweep.
          acc_rd    = 1'b1;
          addr      = '0;
          phase_nxt = PH_READ;
        end
        PH_READ: begin
          acc_rd = 1'b1;
          if (&ptr_q) phase_nxt = PH_DONE;
        end
        PH_DONE: acc_rd = 1'b1;
      endcase
    end
  end

  // Phase, pointer and sticky error flag.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      phase_q <= PH_IDLE;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      phase_q <= phase_nxt;
      if (acc_wr || acc_rd) ptr_q <= addr + PTR_ONE;
      if (err_set) err_q <= 1'b1;
    end
  end

  rw_resp_mem #(
    .AW (MEM_AW),
    .DW (DATA_W)
  ) u_mem (
    .clk   (iCLK),
    .we    (acc_wr),
    .re    (acc_rd),
    .addr  (addr[MEM_AW-1:0]),
    .wdata (bus.writedata),
    .rdata (ram_q)
  );

`ifdef RW_RESP_ERR_INJECT_EN
  logic inj_q;

  // Inject flag travels alongside the RAM read so only that read is corrupted.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) inj_q <= 1'b0;
    else         inj_q <= acc_rd & iINJECT;
  end

  assign ram_x = ram_q ^ {{(DATA_W-1){1'b0}}, inj_q};
`else
  assign ram_x = ram_q;
`endif

  // Valid shift register; reset drops every in-flight read.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) vld_pipe <= '0;
    else         vld_pipe <= {vld_pipe[RD_LAT-1:0], acc_rd};
  end

  if (RD_LAT == 1) begin : g_lat1
    assign ret_data = ram_x;
  end else begin : g_latn
    logic [RD_LAT-2:0][DATA_W-1:0] dly;

    // Extra data stages between the RAM register and the output register.
    always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
        dly <= '0;
      end else begin
        dly[0] <= ram_x;
        for (int s = 1; s < RD_LAT - 1; s++) dly[s] <= dly[s-1];
      end
    end

    assign ret_data = dly[RD_LAT-2];
  end

  // Output data register: loads only on a return and holds otherwise, because
  // the initiator compares several cycles after the strobe.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n)                 rdata_q <= '0;
    else if (vld_pipe[RD_LAT-1]) rdata_q <= ret_data;
  end

  assign bus.readdata      = rdata_q;
  assign bus.readdatavalid = vld_pipe[RD_LAT];
  assign bus.phase         = phase_q;
  assign bus.ptr           = ptr_q;
  assign bus.proto_err     = err_q;

endmodule

// File: tb/tb_rw_test_responder.sv
// Bench for rw_test_responder: two instances (RD_LAT 2 and 3) share one
// stimulus stream and are checked every cycle against a word-level model.
module tb_rw_test_responder;
  import rw_test_pkg::*;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int MEM_AW = 4;
  localparam int NW     = 16;
  localparam int LAT_A  = 2;
  localparam int LAT_B  = 3;
  localparam int MAXE   = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int ecount = 0;
  always @(posedge clk) ecount <= ecount + 1;

  logic              s_write = 1'b0;
  logic              s_read  = 1'b0;
  logic              s_inj   = 1'b0;
  logic [DATA_W-1:0] s_wdata = '0;

  rw_test_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_a ();
  rw_test_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_b ();

  assign bus_a.write = s_write;  assign bus_a.read = s_read;  assign bus_a.writedata = s_wdata;
  assign bus_b.write = s_write;  assign bus_b.read = s_read;  assign bus_b.writedata = s_wdata;

  rw_test_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW), .RD_LAT(LAT_A)) u_dut_a (
    .iCLK   (clk),
    .iRST_n (rst_n),
`ifdef RW_RESP_ERR_INJECT_EN
    .iINJECT(s_inj),
`endif
    .bus    (bus_a)
  );

  rw_test_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW), .RD_LAT(LAT_B)) u_dut_b (
    .iCLK   (clk),
    .iRST_n (rst_n),
`ifdef RW_RESP_ERR_INJECT_EN
    .iINJECT(s_inj),
`endif
    .bus    (bus_b)
  );

  logic [DATA_W-1:0] o_rdata [2];
  logic              o_vld   [2];
  logic [1:0]        o_phase [2];
  logic [ADDR_W-1:0] o_ptr   [2];
  logic              o_err   [2];
  assign o_rdata[0] = bus_a.readdata;  assign o_rdata[1] = bus_b.readdata;
  assign o_vld[0]   = bus_a.readdatavalid;  assign o_vld[1] = bus_b.readdatavalid;
  assign o_phase[0] = bus_a.phase;  assign o_phase[1] = bus_b.phase;
  assign o_ptr[0]   = bus_a.ptr;    assign o_ptr[1]   = bus_b.ptr;
  assign o_err[0]   = bus_a.proto_err;  assign o_err[1] = bus_b.proto_err;

  // Reference model: word array, pointer, phase, and a per-edge record of
  // which edges issued a read and what that read must return.
  phase_e            m_phase = PH_IDLE;
  int                m_ptr   = 0;
  bit                m_err   = 1'b0;
  logic [DATA_W-1:0] m_mem  [NW];
  logic [DATA_W-1:0] m_last [2];
  bit                iss_v  [MAXE];
  logic [DATA_W-1:0] iss_d  [MAXE];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic string dn(input int i);
    return (i == 0) ? "lat2" : "lat3";
  endfunction

  task automatic model_clear();
    m_phase = PH_IDLE;
    m_ptr   = 0;
    m_err   = 1'b0;
    m_last[0] = '0;
    m_last[1] = '0;
    for (int k = 0; k < MAXE; k++) iss_v[k] = 1'b0;
  endtask

  task automatic chk_zero();
    for (int i = 0; i < 2; i++) begin
      chk({dn(i), "_rst_rdata"}, o_rdata[i], 0);
      chk({dn(i), "_rst_vld"},   o_vld[i],   0);
      chk({dn(i), "_rst_phase"}, o_phase[i], 0);
      chk({dn(i), "_rst_ptr"},   o_ptr[i],   0);
      chk({dn(i), "_rst_err"},   o_err[i],   0);
    end
  endtask

  // Compare both instances against the model after edge e.
  task automatic chk_edge(input int e);
    int  lat;
    bit  ev;
    for (int i = 0; i < 2; i++) begin
      lat = (i == 0) ? LAT_A : LAT_B;
      ev  = (e >= lat) && iss_v[e-lat];
      if (ev) m_last[i] = iss_d[e-lat];
      chk({dn(i), "_vld"},   o_vld[i],   ev);
      chk({dn(i), "_rdata"}, o_rdata[i], m_last[i]);
      chk({dn(i), "_phase"}, o_phase[i], m_phase);
      chk({dn(i), "_ptr"},   o_ptr[i],   m_ptr);
      chk({dn(i), "_err"},   o_err[i],   m_err);
    end
  endtask

  // One clock: drive strobes (called right after a falling edge), update the
  // model for the next rising edge, then check on the following falling edge.
  task automatic step(input bit w, input bit r, input logic [DATA_W-1:0] wd);
    int e;
    s_write = w;
    s_read  = r;
    s_wdata = wd;
    e = ecount + 1;
    if (w && r) begin
      m_err = 1'b1;
    end else if (w) begin
      if (m_phase == PH_READ) begin
        m_err = 1'b1;
      end else begin
        if (m_phase != PH_WRITE) begin
          m_phase = PH_WRITE;
          m_ptr   = 0;
        end
        m_mem[m_ptr] = wd;
        m_ptr = (m_ptr + 1) % NW;
      end
    end else if (r) begin
      if (m_phase == PH_IDLE || m_phase == PH_WRITE) begin
        m_phase = PH_READ;
        m_ptr   = 0;
      end
      iss_v[e] = 1'b1;
      iss_d[e] = m_mem[m_ptr] ^ {{(DATA_W-1){1'b0}}, s_inj};
      if (m_phase == PH_READ && m_ptr == NW - 1) m_phase = PH_DONE;
      m_ptr = (m_ptr + 1) % NW;
    end
    @(posedge clk);
    @(negedge clk);
    s_write = 1'b0;
    s_read  = 1'b0;
    chk_edge(e);
  endtask

  // Asynchronous reset between edges; outputs must clear at once.
  task automatic reset_mid();
    s_write = 1'b0;
    s_read  = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_zero();
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] rw;
    model_clear();
    repeat (2) @(negedge clk);
    chk_zero();
    rst_n = 1'b1;

    // Full write sweep, then spaced reads back to DONE.
    for (int i = 0; i < NW; i++) step(1'b1, 1'b0, DATA_W'(16'h1000 + i));
    for (int i = 0; i < NW; i++) begin
      step(1'b0, 1'b1, '0);
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);
    end

    // Back-to-back reads in DONE from address 0.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0);
    repeat (4) step(1'b0, 1'b0, '0);

    // Reset with reads still in flight.
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    reset_mid();
    repeat (5) step(1'b0, 1'b0, '0);

    // Collision at ptr 5, then a normal write to 5.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DATA_W'(16'h2000 + i));
    step(1'b1, 1'b1, 16'hDEAD);
    step(1'b1, 1'b0, 16'h2005);

    // Write during READ at ptr 2 is ignored; finish the read sweep.
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 16'hBEEF);
    for (int i = 2; i < NW; i++) begin
      step(1'b0, 1'b1, '0);
      step(1'b0, 1'b0, '0);
    end
    repeat (3) step(1'b0, 1'b0, '0);

    // Write in DONE starts a new pass at address 0.
    step(1'b1, 1'b0, 16'h3333);
    step(1'b0, 1'b1, '0);
    repeat (4) step(1'b0, 1'b0, '0);

    // Random strobes and data.
    repeat (400) begin
      rw = $urandom;
`ifdef RW_RESP_ERR_INJECT_EN
      s_inj = ($urandom_range(0, 4) == 0);
`endif
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, rw[DATA_W-1:0]);
    end
    s_inj = 1'b0;
    repeat (5) step(1'b0, 1'b0, '0);

    // Sticky error clears only on reset.
    reset_mid();
    step(1'b0, 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
